// File: rtl/mux7_rr_scheduler_if.sv
// Requester/mux-select bundle for the 7-way round-robin scheduler.
// The scheduler sits on the slave side; requesters drive the master side.
interface mux7_rr_scheduler_if;
  logic [6:0] req;
  logic       rel;
  logic [2:0] sel;
  logic [6:0] grant;
  logic       sel_valid;
  logic       timeout;

  modport master (
    output req,
    output rel,
    input  sel,
    input  grant,
    input  sel_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  rel,
    output sel,
    output grant,
    output sel_valid,
    output timeout
  );
endinterface

// File: rtl/mux7_rr_scheduler.sv
// Round-robin owner scheduler for a shared 7-to-1 mux datapath.
// One owner at a time, held until release, request drop or hold expiry.
module mux7_rr_scheduler #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  mux7_rr_scheduler_if.slave   bus
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [2:0]         sel_q, sel_d;
  logic [6:0]         grant_q, grant_d;
  logic               sel_valid_q, sel_valid_d;
  logic               timeout_q, timeout_d;

  logic               found;
  logic [2:0]         pick;
  logic [3:0]         cand;
  logic               own_req;
  logic               hold_done;

  // Descending scan so the last hit is the one closest to ptr.
  always_comb begin
    found = 1'b0;
    pick  = 3'd0;
    cand  = 4'd0;
    for (int k = 6; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + 4'(k);
      if (cand >= 4'd7) cand = cand - 4'd7;
      if (bus.req[cand[2:0]]) begin
        found = 1'b1;
        pick  = cand[2:0];
      end
    end
  end

  assign own_req   = bus.req[sel_q];
  assign hold_done = (hold_cnt_q == CNT_W'(MAX_HOLD));

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    sel_d       = sel_q;
    grant_d     = grant_q;
    sel_valid_d = sel_valid_q;
    timeout_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = GRANT;
          sel_d       = pick;
          grant_d     = 7'(1) << pick;
          sel_valid_d = 1'b1;
          hold_cnt_d  = CNT_W'(1);
        end
      end
      GRANT: begin
        if (bus.rel || !own_req || hold_done) begin
          state_d     = IDLE;
          sel_d       = 3'b111;
          grant_d     = 7'd0;
          sel_valid_d = 1'b0;
          hold_cnt_d  = '0;
          ptr_d       = (sel_q == 3'd6) ? 3'd0 : sel_q + 3'd1;
          timeout_d   = !bus.rel && own_req;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= 3'd0;
      hold_cnt_q  <= '0;
      sel_q       <= 3'b111;
      grant_q     <= 7'd0;
      sel_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      sel_q       <= sel_d;
      grant_q     <= grant_d;
      sel_valid_q <= sel_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.grant     = grant_q;
  assign bus.sel_valid = sel_valid_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_mux7_rr_scheduler.sv
// Scoreboard bench for mux7_rr_scheduler: ownership model feeds a queue,
// a negedge monitor compares the registered outputs.
module tb_mux7_rr_scheduler;

  localparam int MAX_HOLD = 8;

  typedef struct {
    logic [2:0] sel;
    logic [6:0] grant;
    logic       v;
    logic       to;
  } exp_t;

  logic clock;
  logic reset;

  mux7_rr_scheduler_if bus ();

  mux7_rr_scheduler #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  exp_t q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  int   m_owner;
  int   m_held;
  int   m_ptr;
  logic m_to;

  function automatic exp_t model_out();
    exp_t e;
    e.sel   = (m_owner < 0) ? 3'd7 : 3'(m_owner);
    e.grant = (m_owner < 0) ? 7'd0 : 7'(1 << m_owner);
    e.v     = (m_owner >= 0);
    e.to    = m_to;
    return e;
  endfunction

  function automatic void model_reset();
    m_owner = -1;
    m_held  = 0;
    m_ptr   = 0;
    m_to    = 1'b0;
  endfunction

  function automatic void model_step(logic [6:0] r, logic l);
    m_to = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < 7; k++) begin
        int i;
        i = (m_ptr + k) % 7;
        if (r[i] && m_owner < 0) begin
          m_owner = i;
          m_held  = 1;
        end
      end
    end else if (l || !r[m_owner] || m_held == MAX_HOLD) begin
      m_to    = !l && r[m_owner];
      m_ptr   = (m_owner + 1) % 7;
      m_owner = -1;
      m_held  = 0;
    end else begin
      m_held++;
    end
  endfunction

  task automatic check(string name, exp_t e);
    vectors++;
    if (bus.sel !== e.sel || bus.grant !== e.grant ||
        bus.sel_valid !== e.v || bus.timeout !== e.to) begin
      miscompares++;
      $display("FAIL %s t=%0t got sel=%0d grant=%b v=%b to=%b want sel=%0d grant=%b v=%b to=%b",
               name, $time, bus.sel, bus.grant, bus.sel_valid, bus.timeout,
               e.sel, e.grant, e.v, e.to);
    end
  endtask

  always @(negedge clock) begin
    if (q.size() > 0) check("cycle", q.pop_front());
  end

  // Called just after a posedge: drive inputs, then model the next edge.
  task automatic apply(logic [6:0] r, logic l);
    bus.req = r;
    bus.rel = l;
    @(posedge clock);
    model_step(r, l);
    q.push_back(model_out());
    #1;
  endtask

  // Asynchronous reset between edges; outputs must drop immediately.
  task automatic mid_reset();
    #1 reset = 1'b1;
    q.delete();
    #1;
    model_reset();
    check("async_reset", model_out());
    @(posedge clock);
    q.push_back(model_out());
    #1 reset = 1'b0;
  endtask

  logic [6:0] rr;

  initial begin
    reset   = 1'b1;
    bus.req = 7'd0;
    bus.rel = 1'b0;
    model_reset();
    #1;
    check("reset_state", model_out());
    @(posedge clock);
    #1 reset = 1'b0;

    repeat (3) apply(7'd0, 1'b0);
    apply(7'b0000100, 1'b0);
    apply(7'b0000100, 1'b1);
    apply(7'b0000000, 1'b0);

    for (int n = 0; n < 16; n++) apply(7'b1111111, m_owner >= 0);
    apply(7'd0, 1'b0);

    for (int n = 0; n < 22; n++) apply(7'b0100000, 1'b0);
    apply(7'd0, 1'b0);

    apply(7'b0001000, 1'b0);
    apply(7'b0001000, 1'b0);
    apply(7'b0000000, 1'b0);
    apply(7'b0000011, 1'b0);
    apply(7'b0000011, 1'b1);
    apply(7'd0, 1'b0);

    apply(7'b1000000, 1'b0);
    apply(7'b1000000, 1'b0);
    apply(7'b1000000, 1'b0);
    mid_reset();
    apply(7'b1000001, 1'b0);
    apply(7'b1000001, 1'b1);
    apply(7'd0, 1'b0);

    rr = 7'd0;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 7; b++)
        if ($urandom_range(0, 11) == 0) rr[b] = ~rr[b];
      if ($urandom_range(0, 399) == 0) mid_reset();
      else apply(rr, $urandom_range(0, 15) == 0);
    end

    apply(7'd0, 1'b0);
    @(negedge clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
